// File: rtl/depuncturer_pkg.sv
// Shared rate codes, puncturing periods and keep masks for the 802.11a receive chain.
// The Viterbi decoder uses the same rate codes.
package depuncturer_pkg;

   localparam logic [1:0] RATE_1_2  = 2'd0;
   localparam logic [1:0] RATE_2_3  = 2'd1;
   localparam logic [1:0] RATE_3_4  = 2'd2;
   localparam logic [1:0] RATE_RSVD = 2'd3;

   localparam logic [2:0] PERIOD_1_2 = 3'd2;
   localparam logic [2:0] PERIOD_2_3 = 3'd4;
   localparam logic [2:0] PERIOD_3_4 = 3'd6;

   // Leftmost bit is phase 0; slot order A,B,A,B,...; 1 = keep.
   localparam logic [1:0] MASK_1_2 = 2'b11;
   localparam logic [3:0] MASK_2_3 = 4'b1110;
   localparam logic [5:0] MASK_3_4 = 6'b111001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   function automatic logic [1:0] sanitize_rate(input logic [1:0] rate);
      return (rate == RATE_RSVD) ? RATE_1_2 : rate;
   endfunction

endpackage

// File: rtl/depuncturer_pattern.sv
// Combinational puncturing pattern lookup: (rate, phase) -> keep flag and end-of-period flag.
module depuncture_pattern
   import depuncturer_pkg::*;
(
   input  logic [1:0] i_rate,
   input  logic [2:0] i_phase,
   output logic       o_keep,
   output logic       o_last_phase
);

   logic [5:0] w_mask;
   logic [5:0] w_shifted;
   logic [2:0] w_last;

   // Masks are left-aligned in a 6-bit field so bit 5 always lines up with phase 0.
   always_comb begin
      w_mask = {MASK_1_2, 4'b0000};
      w_last = PERIOD_1_2 - 3'd1;
      case (i_rate)
         RATE_2_3: begin
            w_mask = {MASK_2_3, 2'b00};
            w_last = PERIOD_2_3 - 3'd1;
         end
         RATE_3_4: begin
            w_mask = MASK_3_4;
            w_last = PERIOD_3_4 - 3'd1;
         end
         default: ;
      endcase
   end

   assign w_shifted    = w_mask << i_phase;
   assign o_keep       = w_shifted[5];
   assign o_last_phase = (i_phase == w_last);

endmodule

// File: rtl/depuncturer.sv
// Depuncturer: restores the rate-1/2 A/B slot stream from punctured 802.11a input,
// inserting zero-valued erasure slots for stolen bits.
module depuncturer
   import depuncturer_pkg::*;
#(
   parameter int CNT_W = 12
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Frame_Start,
   input  logic [1:0]       Rate,
   input  logic             In_Bit,
   input  logic             In_Valid,
   input  logic             In_Last,
   output logic             In_Ready,
   output logic             Out_Bit,
   output logic             Out_Erase,
   output logic             Out_Valid,
   output logic             Out_Last,
   input  logic             Out_Ready,
   output logic [CNT_W-1:0] Slot_Count,
   output logic             Rate_Err
);

   state_t           r_state, w_next_state;
   logic [1:0]       r_rate;
   logic [2:0]       r_phase;
   logic             r_out_valid, r_out_bit, r_out_erase, r_out_last;
   logic [CNT_W-1:0] r_slot_cnt;
   logic             r_rate_err;

   logic w_keep, w_last_phase;
   logic w_load, w_xfer;
   logic w_load_keep, w_load_erase;

   depuncture_pattern u_pattern (
      .i_rate       (r_rate),
      .i_phase      (r_phase),
      .o_keep       (w_keep),
      .o_last_phase (w_last_phase)
   );

   assign w_load = !r_out_valid || Out_Ready;
   assign w_xfer = r_out_valid && Out_Ready;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (Frame_Start) begin
         w_next_state = ST_RUN;
      end else begin
         case (r_state)
            ST_RUN:   if (w_load_keep && In_Last) w_next_state = w_last_phase ? ST_IDLE : ST_FLUSH;
            ST_FLUSH: if (w_xfer && r_out_last)   w_next_state = ST_IDLE;
            default:  ;
         endcase
      end
   end

   // FLUSH stops loading once the Out_Last slot is sitting in the register.
   always_comb begin
      In_Ready     = 1'b0;
      w_load_keep  = 1'b0;
      w_load_erase = 1'b0;
      if (!Frame_Start && w_load) begin
         case (r_state)
            ST_RUN: begin
               if (w_keep) begin
                  In_Ready    = 1'b1;
                  w_load_keep = In_Valid;
               end else begin
                  w_load_erase = 1'b1;
               end
            end
            ST_FLUSH: w_load_erase = !(r_out_valid && r_out_last);
            default:  ;
         endcase
      end
   end

   // r_phase is the phase of the next slot to enter the output register; it only moves when a
   // slot is loaded, which under backpressure is exactly when the previous slot transfers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_rate      <= RATE_1_2;
         r_rate_err  <= 1'b0;
         r_phase     <= 3'd0;
         r_slot_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out_bit   <= 1'b0;
         r_out_erase <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (Frame_Start) begin
         r_rate      <= sanitize_rate(Rate);
         r_rate_err  <= (Rate == RATE_RSVD);
         r_phase     <= 3'd0;
         r_slot_cnt  <= '0;
         r_out_valid <= 1'b0;
         r_out_bit   <= 1'b0;
         r_out_erase <= 1'b0;
         r_out_last  <= 1'b0;
      end else begin
         if (w_xfer && (r_slot_cnt != {CNT_W{1'b1}}))
            r_slot_cnt <= r_slot_cnt + 1'b1;
         if (w_load_keep || w_load_erase) begin
            r_out_valid <= 1'b1;
            r_out_bit   <= w_load_keep && In_Bit;
            r_out_erase <= w_load_erase;
            r_out_last  <= w_last_phase && (w_load_erase ? (r_state == ST_FLUSH) : In_Last);
            r_phase     <= w_last_phase ? 3'd0 : r_phase + 3'd1;
         end else if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_erase <= 1'b0;
            r_out_last  <= 1'b0;
         end
      end
   end

   assign Out_Valid  = r_out_valid;
   assign Out_Bit    = r_out_bit;
   assign Out_Erase  = r_out_erase;
   assign Out_Last   = r_out_last;
   assign Slot_Count = r_slot_cnt;
   assign Rate_Err   = r_rate_err;

endmodule
